// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity
// selection constants and the serial idle level.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // xor_red is the XOR-reduction of the data word.
  function automatic logic parity_bit(input logic xor_red, input logic par_typ);
    return (par_typ == PAR_ODD) ? ~xor_red : xor_red;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter and data-bit index for the UART transmitter.
// bit_done marks the last clk of a bit; last_bit marks the final data bit.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PRE_W  = 6,
  parameter int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             bit_step,
  input  logic [PRE_W-1:0] prescale,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             bit_done,
  output logic             last_bit
);

  logic [PRE_W-1:0] edge_cnt;

  assign bit_done = (edge_cnt == prescale - PRE_W'(1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
    end else if (run) begin
      edge_cnt <= bit_done ? '0 : edge_cnt + PRE_W'(1);
    end
  end

  // bit_cnt only advances at a bit boundary while data bits are shifting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (run && bit_step && bit_done) begin
      bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: valid/ready word intake, frame sequencing
// (start, LSB-first data, optional parity, stop) and registered TX_OUT.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PRE_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              DATA_VALID,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [PRE_W-1:0]  Prescale,
  output logic              ready,
  output logic              busy,
  output logic              TX_OUT
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state, state_next;
  logic [DATA_W-1:0] data_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic [PRE_W-1:0]  prescale_q;
  logic              tx_q, tx_next;
  logic              transfer;
  logic              parity;
  logic              bit_done, last_bit;
  logic [BIT_W-1:0]  bit_cnt, bit_idx;

  uart_tx_bit_timer #(
    .DATA_W (DATA_W),
    .PRE_W  (PRE_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (transfer),
    .run      (state != IDLE),
    .bit_step (state == DATA),
    .prescale (prescale_q),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done),
    .last_bit (last_bit)
  );

  assign ready    = (state == IDLE) || (state == STOP && bit_done);
  assign busy     = (state != IDLE);
  assign transfer = DATA_VALID && ready;
  assign parity   = parity_bit(^data_q, par_typ_q);
  assign TX_OUT   = tx_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && last_bit) state_next = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) state_next = STOP;
      STOP:    if (bit_done) state_next = transfer ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // TX_OUT is registered, so select the data bit that will be on the line next cycle.
  always_comb begin
    bit_idx = bit_cnt;
    if (state != DATA) begin
      bit_idx = '0;
    end else if (bit_done && !last_bit) begin
      bit_idx = bit_cnt + BIT_W'(1);
    end
  end

  always_comb begin
    tx_next = IDLE_LEVEL;
    case (state_next)
      IDLE:    tx_next = IDLE_LEVEL;
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[bit_idx];
      PARITY:  tx_next = parity;
      STOP:    tx_next = 1'b1;
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tx_q       <= IDLE_LEVEL;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      prescale_q <= '0;
    end else begin
      state <= state_next;
      tx_q  <= tx_next;
      if (transfer) begin
        data_q     <= P_DATA;
        par_en_q   <= PAR_EN;
        par_typ_q  <= PAR_TYP;
        prescale_q <= Prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a frame-level model checked every cycle
// plus literal expectations for bit patterns, frame lengths and reset.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       ready, busy, TX_OUT;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_W(8), .PRE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .ready      (ready),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of bits, each held m_p cycles.
  bit          m_active = 1'b0;
  int          m_t = 0;
  int          m_p = 1;
  int          m_n = 1;
  logic [15:0] m_bits = 16'h0;
  logic        exp_tx, exp_busy, exp_ready;

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic pe, input logic pt);
    logic [15:0] fb;
    int ones;
    fb = 16'h0;
    ones = 0;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb[i+1] = d[i];
      if (d[i]) ones++;
    end
    if (pe) begin
      fb[9]  = ((ones % 2) == 1) ^ pt;
      fb[10] = 1'b1;
    end else begin
      fb[9] = 1'b1;
    end
    return fb;
  endfunction

  always_comb begin
    exp_tx    = 1'b1;
    exp_busy  = m_active;
    exp_ready = !m_active || (m_t == m_n * m_p - 1);
    if (m_active) exp_tx = m_bits[m_t / m_p];
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_active <= 1'b0;
    end else if (DATA_VALID && exp_ready) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_p      <= int'(Prescale);
      m_n      <= PAR_EN ? 11 : 10;
      m_bits   <= frame_bits(P_DATA, PAR_EN, PAR_TYP);
    end else if (m_active) begin
      if (m_t == m_n * m_p - 1) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_out", {31'b0, TX_OUT}, {31'b0, exp_tx});
      chk("busy",   {31'b0, busy},   {31'b0, exp_busy});
      chk("ready",  {31'b0, ready},  {31'b0, exp_ready});
    end
  end

  // Called at a negedge with DUT idle; returns at the first frame cycle.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = pre; DATA_VALID = 1'b1;
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  // Samples TX_OUT at the middle of each bit and counts busy cycles.
  task automatic capture(input int pre, input int inj, output int nb, output logic [15:0] bits);
    int c;
    nb = 0; bits = 16'h0; c = 0;
    while (busy && c < 1000) begin
      if ((c % pre) == pre / 2 && (c / pre) < 16) bits[c / pre] = TX_OUT;
      if (inj >= 0 && c == inj) begin
        DATA_VALID = 1'b1; P_DATA = 8'h3C; PAR_EN = ~PAR_EN; Prescale = 6'd4;
      end
      if (inj >= 0 && c == inj + 3) DATA_VALID = 1'b0;
      nb++; c++;
      @(negedge clk);
    end
    if (c >= 1000) chk("frame_timeout", 32'(c), 32'd0);
  endtask

  int          nb;
  logic [15:0] bits;

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx",    {31'b0, TX_OUT}, 32'd1);
    chk("rst_busy",  {31'b0, busy},   32'd0);
    chk("rst_ready", {31'b0, ready},  32'd1);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // A5, prescale 8, even parity
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    chk("a5_ready_low", {31'b0, ready}, 32'd0);
    capture(8, -1, nb, bits);
    chk("a5_bits", {16'b0, bits}, 32'h054A);
    chk("a5_len",  32'(nb), 32'd88);
    repeat (3) @(negedge clk);

    // odd parity, prescale 16
    send(8'h01, 1'b1, 1'b1, 6'd16);
    capture(16, -1, nb, bits);
    chk("01_bits", {16'b0, bits}, 32'h0402);
    chk("01_len",  32'(nb), 32'd176);
    @(negedge clk);
    send(8'h03, 1'b1, 1'b1, 6'd16);
    capture(16, -1, nb, bits);
    chk("03_bits", {16'b0, bits}, 32'h0606);
    chk("03_len",  32'(nb), 32'd176);
    @(negedge clk);

    // no parity slot
    send(8'hFF, 1'b0, 1'b0, 6'd16);
    capture(16, -1, nb, bits);
    chk("ff_bits", {16'b0, bits}, 32'h03FE);
    chk("ff_len",  32'(nb), 32'd160);
    @(negedge clk);

    // back-to-back frames with DATA_VALID held high
    begin
      int c2;
      logic prev_tx;
      bit drop;
      P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8; DATA_VALID = 1'b1;
      @(negedge clk);
      P_DATA = 8'hFF;
      prev_tx = TX_OUT;
      drop = 1'b0;
      c2 = 0;
      while (c2 < 300) begin
        if (!busy) drop = 1'b1;
        @(negedge clk);
        c2++;
        if (prev_tx == 1'b1 && TX_OUT == 1'b0) break;
        prev_tx = TX_OUT;
      end
      DATA_VALID = 1'b0;
      chk("b2b_gap",  32'(c2), 32'd80);
      chk("b2b_busy", {31'b0, drop}, 32'd0);
      capture(8, -1, nb, bits);
      chk("b2b_len2", 32'(nb), 32'd80);
    end
    @(negedge clk);

    // inputs changed mid-frame during data bit 3 are ignored
    send(8'h5A, 1'b1, 1'b0, 6'd8);
    capture(8, 34, nb, bits);
    chk("inj_bits", {16'b0, bits}, 32'h04B4);
    chk("inj_len",  32'(nb), 32'd88);
    chk("inj_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);

    // reset aborts a frame during data bit 3
    send(8'hA5, 1'b1, 1'b0, 6'd8);
    repeat (34) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tx",    {31'b0, TX_OUT}, 32'd1);
    chk("abort_busy",  {31'b0, busy},   32'd0);
    chk("abort_ready", {31'b0, ready},  32'd1);
    rst = 1'b1;
    @(negedge clk);
    send(8'hC3, 1'b1, 1'b1, 6'd4);
    capture(4, -1, nb, bits);
    chk("post_rst_bits", {16'b0, bits}, 32'h0786);
    chk("post_rst_len",  32'(nb), 32'd44);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller and serializer, the transmit-side companion of the UART RX path. It accepts a parallel word with a valid/ready handshake, latches the word and the frame configuration, and sequences start, data (LSB first), optional parity and stop bits onto TX_OUT. Each bit lasts Prescale clk cycles. It sits between the system/register-file side and the serial line.

Parameters:
DATA_W, 8, data bits per frame
PRE_W, 6, width of Prescale input and of the internal edge counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
P_DATA  in  DATA_W  parallel word to transmit
DATA_VALID  in  1  P_DATA valid; transfer occurs when DATA_VALID && ready are both high on a clk edge
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even, 1 = odd
Prescale  in  PRE_W  clk cycles per bit; legal range 4..32
ready  out  1  controller can accept a word this cycle
busy  out  1  frame in progress
TX_OUT  out  1  serial line, idle high, registered

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; TX_OUT=1, busy=0, ready=1, edge and bit counters = 0, data and config registers = 0. Reset takes effect at the next edge and aborts any frame mid-bit. No partial bit follows reset.
- States: IDLE, START, DATA, PARITY, STOP. Enum in package.
- ready = (state==IDLE) || (state==STOP && edge_cnt==Prescale_q-1). Combinational from registered state.
- Accept: on a transfer, latch P_DATA, PAR_EN, PAR_TYP and Prescale into _q registers. Compute parity from the latched data: even = ^data, odd = ~^data. Go to START and clear edge_cnt. TX_OUT=0 and busy=1 from the next cycle, so latency is 1 clk from accept to the start-bit edge.
- DATA_VALID while ready=0 is ignored. There is no queue and the current frame is unaffected.
- Changes to PAR_EN, PAR_TYP or Prescale mid-frame do not affect the current frame.
- Bit timing: edge_cnt counts 0..Prescale_q-1 in every non-IDLE state. At Prescale_q-1 it wraps to 0 and the state or bit advances. Each bit is held exactly Prescale_q cycles.
- START → DATA at the wrap.
- DATA: TX_OUT = data_q[bit_cnt], with bit_cnt running 0..DATA_W-1 and incrementing on each wrap. On the wrap at bit_cnt==DATA_W-1:
  - PAR_EN_q=1 → PARITY
  - PAR_EN_q=0 → STOP
  - bit_cnt clears.
- PARITY: TX_OUT = parity_q. Goes to STOP at the wrap.
- STOP: TX_OUT=1. At the wrap:
  - transfer occurring → START; busy stays 1, no idle cycle between frames.
  - otherwise → IDLE; busy=0.
- Frame length = (2 + DATA_W + PAR_EN_q) * Prescale_q clk cycles.
- TX_OUT is driven from a register loaded with the next-state bit value. No combinational path from inputs to TX_OUT.
- Prescale values outside 4..32 are illegal. Implementation need not check them. The bench must not drive them.

Decomposition:
- Shared package uart_pkg contains:
  - tx_state_e enum {IDLE, START, DATA, PARITY, STOP}
  - constants PAR_EVEN=1'b0 and PAR_ODD=1'b1
  - IDLE_LEVEL=1'b1
- One natural sub-module: uart_tx_bit_timer. It holds edge_cnt and bit_cnt with clear/enable inputs and exposes bit_done (edge_cnt==Prescale_q-1) and last_bit (bit_cnt==DATA_W-1).
- FSM, data/config registers and the TX_OUT register stay in uart_tx_ctrl.

Test Plan:
- Reset, then Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=8'hA5, one-cycle DATA_VALID → TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,0(parity),1. Each bit holds 8 cycles, 88 cycles total; busy high for exactly 88 cycles; ready low between accept and the last STOP cycle.
- Prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=8'h01 → parity bit 0, frame 176 cycles. Repeat with 8'h03 → parity bit 1.
- Prescale=16, PAR_EN=0, P_DATA=8'hFF → 0 followed by nine 1s, 160 cycles, no parity slot.
- DATA_VALID held high with 8'h00 then 8'hFF, Prescale=8, PAR_EN=0 → second start bit begins exactly 80 cycles after the first, with no idle cycle; busy never drops between the frames.
- Mid-frame during DATA bit 3: drive DATA_VALID with 8'h3C and flip PAR_EN and Prescale → ignored; current frame bits and timing unchanged.
- Assert rst=0 for one cycle during DATA bit 3 → next cycle TX_OUT=1, busy=0, ready=1. A new word accepted afterward is transmitted correctly from its start bit.
